tdm_mux_8to1: RTL and testbench

- Merges 8 independent input channels onto one shared output lane using round-robin arbitration, with valid/ready handshakes on both sides.
- Every output word carries its 3-bit source channel index. The existing 1:8 demux can use that index as its select to split the stream back into 8 channels.
- Used as the combining end of a shared-lane link: channel producers upstream, the lane/demux downstream.

---
 rtl/tdm_mux_8to1.sv | 108 ++++++++++
 tb/tb_tdm_mux_8to1.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_8to1.sv
// tdm_mux_8to1: merges eight valid/ready channels onto one registered output
// lane using a rotating-priority (round-robin) arbiter. Every output word is
// tagged with its source channel index so a downstream 1:8 demux can split
// the stream back out.
module tdm_mux_8to1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready,
  output logic [3:0]         busy_cnt
);

  // Number of asserted request lines (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, vec[k]};
    end
    return cnt;
  endfunction

  logic [2:0]       ptr_r;        // channel with highest priority next
  logic             load_s;       // output register may take a new word
  logic             grant_found_s;
  logic [2:0]       grant_idx_s;
  logic [2:0]       scan_idx_s;
  logic             take_s;       // a transfer happens on this edge
  logic [WIDTH-1:0] grant_data_s;

  // Output register is free when empty or being drained this cycle.
  assign load_s = !out_valid || out_ready;

  // Rotating scan: first requesting channel starting at ptr_r, modulo 8.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    scan_idx_s    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx_s = ptr_r + 3'(k);
      if (!grant_found_s && in_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A grant only completes when the output register can accept it.
  assign take_s       = load_s && grant_found_s;
  assign grant_data_s = in_data[grant_idx_s*WIDTH +: WIDTH];

  // One-hot ready toward the granted producer; held low during reset.
  always_comb begin
    in_ready = 8'h00;
    if (rst_n && take_s) begin
      in_ready = 8'h01 << grant_idx_s;
    end else begin
      in_ready = 8'h00;
    end
  end

  // Output word register: load on grant, empty when drained with no request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
    end else if (take_s) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_s;
      out_sel   <= grant_idx_s;
    end else if (load_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 3'd0;
    end else if (take_s) begin
      ptr_r <= grant_idx_s + 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered count of channels currently requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 4'd0;
    end else begin
      busy_cnt <= popcount8(in_valid);
    end
  end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Self-checking bench for tdm_mux_8to1: a cycle model of the arbiter checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_tdm_mux_8to1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   out_sel;
  logic         out_ready;
  logic [3:0]   busy_cnt;

  int checks = 0;
  int errors = 0;

  tdm_mux_8to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_ptr   = 0;
  int m_valid = 0;
  int m_data  = 0;
  int m_sel   = 0;
  int m_busy  = 0;

  // First requesting channel scanning ptr, ptr+1, ... modulo 8; -1 if none.
  function automatic int pick(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // Model state update on each edge or on asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_valid <= 0; m_data <= 0; m_sel <= 0; m_busy <= 0;
    end else begin
      int g;
      m_busy <= $countones(in_valid);
      g = pick(in_valid, m_ptr);
      if (m_valid == 0 || out_ready) begin
        if (g >= 0) begin
          m_valid <= 1;
          m_data  <= int'(in_data[g*W +: W]);
          m_sel   <= g;
          m_ptr   <= (g + 1) % 8;
        end else begin
          m_valid <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    int g;
    int exp_rdy;
    g = pick(in_valid, m_ptr);
    exp_rdy = (rst_n && (m_valid == 0 || out_ready) && g >= 0) ? (1 << g) : 0;
    chk("model in_ready", int'(in_ready), exp_rdy);
    chk("model out_valid", int'(out_valid), m_valid);
    chk("model out_data", int'(out_data), m_data);
    chk("model out_sel", int'(out_sel), m_sel);
    chk("model busy_cnt", int'(busy_cnt), m_busy);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #2;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] val);
    in_data[ch*W +: W] = val;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 8'h00; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy_cnt", int'(busy_cnt), 0);
    rst_n = 1'b1;

    // Idle: nothing requested.
    tick(); probe();
    chk("idle out_valid", int'(out_valid), 0);
    chk("idle in_ready", int'(in_ready), 8'h00);
    chk("idle busy_cnt", int'(busy_cnt), 0);

    // All channels requesting: grants 0..7 then wrap to 0.
    tick();
    for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h10 + i));
    in_valid = 8'hFF;
    probe();
    chk("all first in_ready", int'(in_ready), 8'h01);
    for (int k = 0; k < 9; k++) begin
      tick(); probe();
      chk("rr out_sel", int'(out_sel), k % 8);
      chk("rr out_data", int'(out_data), 8'h10 + (k % 8));
      chk("rr out_valid", int'(out_valid), 1);
      chk("rr busy_cnt", int'(busy_cnt), 8);
    end
    tick();
    in_valid = 8'h00;
    tick(); probe();
    chk("drain out_valid", int'(out_valid), 0);

    // Single channel 5.
    set_ch(5, 8'hA5); in_valid = 8'h20;
    probe();
    chk("ch5 in_ready", int'(in_ready), 8'h20);
    tick();
    in_valid = 8'h00; out_ready = 1'b0;
    probe();
    chk("ch5 out_valid", int'(out_valid), 1);
    chk("ch5 out_sel", int'(out_sel), 5);
    chk("ch5 out_data", int'(out_data), 8'hA5);

    // Stall with channels 2 and 3 waiting.
    set_ch(2, 8'h22); set_ch(3, 8'h33); in_valid = 8'h0C;
    for (int k = 0; k < 3; k++) begin
      probe();
      chk("stall in_ready", int'(in_ready), 8'h00);
      chk("stall out_sel", int'(out_sel), 5);
      chk("stall out_data", int'(out_data), 8'hA5);
      tick();
    end
    out_ready = 1'b1;
    probe();
    chk("release in_ready", int'(in_ready), 8'h04);
    tick();
    in_valid = 8'h08;
    probe();
    chk("release sel2", int'(out_sel), 2);
    chk("release data2", int'(out_data), 8'h22);
    chk("release in_ready3", int'(in_ready), 8'h08);
    tick();
    in_valid = 8'h00;
    probe();
    chk("release sel3", int'(out_sel), 3);
    chk("release data3", int'(out_data), 8'h33);
    tick(); probe();
    chk("release empty", int'(out_valid), 0);

    // Reset mid-stream while a word is held.
    tick();
    set_ch(0, 8'h44); set_ch(7, 8'h77); in_valid = 8'h01;
    tick();
    in_valid = 8'h00; out_ready = 1'b0;
    probe();
    chk("pre-reset out_valid", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset in_ready", int'(in_ready), 8'h00);
    tick();
    rst_n = 1'b1;

    // Fairness after reset: channels 0 and 7 alternate, starting at 0.
    in_valid = 8'h81; out_ready = 1'b1;
    probe();
    chk("fair first in_ready", int'(in_ready), 8'h01);
    for (int k = 0; k < 4; k++) begin
      tick(); probe();
      chk("fair out_sel", int'(out_sel), (k % 2 == 0) ? 0 : 7);
      chk("fair out_data", int'(out_data), (k % 2 == 0) ? 8'h44 : 8'h77);
    end
    tick();
    in_valid = 8'h00;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
